// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder: slice width and FSM encodings.
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage : nibble_serial_adder_pkg

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle between a requester and the nibble-serial adder.
interface nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow, busy
    );

endinterface : nibble_serial_adder_if

// File: rtl/nibble_serial_adder_rca.sv
// Four-bit ripple-carry adder slice reused once per nibble by the serial adder.
module four_bit_rca (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [4:0] w_c;

    assign w_c[0] = Cin;

    // Full-adder chain, carry ripples from bit 0 upward
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign S[i]     = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end

    assign Cout = w_c[4];

endmodule : four_bit_rca

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit RCA slice walked across the operands nibble by nibble.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [3:0]       w_s;
    logic             w_cout;
    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_fin;

    // Shared nibble slice: low nibble of each shift register plus running carry
    four_bit_rca u_rca (
        .A    (r_a_sh[3:0]),
        .B    (r_b_sh[3:0]),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_cout)
    );

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_run    = (r_state == S_RUN);
    assign w_last   = w_run && (r_idx == IDX_W'(NIBBLES - 1));

    // Partial sum with the current slice result dropped into nibble position idx
    always_comb begin
        w_sum_fin = r_sum_sh;
        w_sum_fin[r_idx * NIBBLE_W +: NIBBLE_W] = w_s;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: IDLE -> RUN -> DONE -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid)  w_state_nxt = S_RUN;
            S_RUN:  if (w_last)        w_state_nxt = S_DONE;
            S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, per-nibble shift/accumulate, and result latch on the final nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_sum_sh <= '0;
            r_carry  <= bus.cin;
            r_idx    <= '0;
            r_a_msb  <= bus.a[WIDTH-1];
            r_b_msb  <= bus.b[WIDTH-1];
        end else if (w_run) begin
            r_a_sh   <= r_a_sh >> NIBBLE_W;
            r_b_sh   <= r_b_sh >> NIBBLE_W;
            r_sum_sh <= w_sum_fin;
            r_carry  <= w_cout;
            r_idx    <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_sum  <= w_sum_fin;
                r_cout <= w_cout;
                r_ovf  <= (r_a_msb == r_b_msb) && (w_s[3] != r_a_msb);
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.overflow  = r_ovf;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16): driver queues expected results, monitor checks them.
module tb_nibble_serial_adder;

    localparam int unsigned W       = 16;
    localparam int unsigned NIBBLES = W / 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rand_mode;
    logic or_force;
    logic seen;

    int   errors     = 0;
    int   checks     = 0;
    int   cyc        = 0;
    int   accept_cyc = 0;

    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    nibble_serial_adder_if #(.WIDTH(W)) bus ();

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Downstream ready: forced value in directed phases, random stalls in the random phase
    always @(posedge clk) begin
        #2;
        bus.out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : or_force;
    end

    // Monitor: latency check on first out_valid, scoreboard compare on each handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                chk("latency", 32'(cyc - accept_cyc), 32'(NIBBLES));
            end
            if (bus.out_ready) begin
                seen = 1'b0;
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'(1), 32'(0));
                end else begin
                    mon_e = q.pop_front();
                    chk("sum",      32'(bus.sum),      32'(mon_e.sum));
                    chk("cout",     32'(bus.cout),     32'(mon_e.cout));
                    chk("overflow", 32'(bus.overflow), 32'(mon_e.ovf));
                end
            end
        end
    end

    // Issue one operation; returns 1ns after the accepting edge
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input exp_t e);
        int n;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        if (!bus.in_ready) begin
            chk("accept_timeout", 32'(0), 32'(1));
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        q.push_back(e);
        #1;
        accept_cyc   = cyc;
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.cin      = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] hold_sum;
        logic         hold_cout;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   full;
        exp_t         e;
        int           n;

        rst_n        = 1'b0;
        rand_mode    = 1'b0;
        or_force     = 1'b1;
        seen         = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready",  32'(bus.in_ready),  32'(1));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_busy",      32'(bus.busy),      32'(0));
        chk("rst_sum",       32'(bus.sum),       32'(0));
        chk("rst_cout",      32'(bus.cout),      32'(0));
        chk("rst_overflow",  32'(bus.overflow),  32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors
        do_op(16'h1234, 16'h4321, 1'b0, '{sum: 16'h5555, cout: 1'b0, ovf: 1'b0});
        do_op(16'hFFFF, 16'h0001, 1'b0, '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0});
        do_op(16'h7FFF, 16'h0001, 1'b0, '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1});
        do_op(16'h8000, 16'h8000, 1'b1, '{sum: 16'h0001, cout: 1'b1, ovf: 1'b1});
        drain();

        // Backpressure: result held for 5 cycles, new in_valid ignored
        or_force = 1'b0;
        do_op(16'hFFFF, 16'h0001, 1'b0, '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 50);
        chk("bp_out_valid", 32'(bus.out_valid), 32'(1));
        hold_sum  = bus.sum;
        hold_cout = bus.cout;
        for (int i = 0; i < 5; i++) begin
            chk("bp_sum_stable",  32'(bus.sum),       32'(hold_sum));
            chk("bp_cout_stable", 32'(bus.cout),      32'(hold_cout));
            chk("bp_in_ready",    32'(bus.in_ready),  32'(0));
            chk("bp_out_valid_h", 32'(bus.out_valid), 32'(1));
            @(posedge clk);
            #1;
            if (i == 1) begin
                bus.in_valid = 1'b1;
                bus.a        = 16'h0101;
                bus.b        = 16'h0202;
            end
            if (i == 3) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        or_force = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready",  32'(bus.in_ready),  32'(1));
        chk("bp_release_out_valid", 32'(bus.out_valid), 32'(0));
        repeat (6) @(negedge clk);
        chk("bp_ignored_busy", 32'(bus.busy), 32'(0));
        chk("bp_queue_empty",  32'(q.size()), 32'(0));
        @(posedge clk);
        #1;

        // Reset mid-RUN aborts the operation
        do_op(16'h1234, 16'h1111, 1'b0, '{sum: 16'h2345, cout: 1'b0, ovf: 1'b0});
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'(0));
        chk("abort_in_ready",  32'(bus.in_ready),  32'(1));
        chk("abort_busy",      32'(bus.busy),      32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(16'h0F0F, 16'h0101, 1'b1, '{sum: 16'h1011, cout: 1'b0, ovf: 1'b0});
        drain();

        // Random back-to-back operations with random downstream stalls
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra    = W'($urandom);
            rb    = W'($urandom);
            rc    = 1'($urandom);
            full  = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
            e.sum  = full[W-1:0];
            e.cout = full[W];
            e.ovf  = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
            do_op(ra, rb, rc, e);
        end
        drain();
        rand_mode = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_nibble_serial_adder
